// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, instruction field
// positions, FSM state encoding and the bundle of datapath controls.
package cu_pkg;

    // Default widths of the program counter and the instruction word
    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 16;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes 0x0..0x9 are passed straight through to the ALU
    localparam logic [3:0] OP_ALU_LAST = 4'h9;
    localparam logic [3:0] OP_ALUI     = 4'hA;
    localparam logic [3:0] OP_LDI      = 4'hB;
    localparam logic [3:0] OP_JMP      = 4'hC;
    localparam logic [3:0] OP_BZ       = 4'hD;
    localparam logic [3:0] OP_BC       = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    // ALU operation code for addition
    localparam logic [3:0] OP_ADD = 4'h0;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } cu_state_t;

    // Everything the sequencer drives into the datapath
    typedef struct packed {
        logic       alu_en;
        logic [3:0] alu_opcode;
        logic [7:0] imm_value;
        logic [3:0] write_addr;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic       write_en;
        logic       imm_flag;
    } dp_ctrl_t;

    // True for the register-register ALU opcodes
    function automatic logic is_alu_rr(input logic [3:0] op);
        return op <= OP_ALU_LAST;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-memory fetch bus: request/address out, valid/data back.
interface control_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;

    // The control unit issues fetches
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    // The instruction memory answers them
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );

endinterface

// File: rtl/control_unit_instr_decoder.sv
// Purely combinational instruction decoder. Produces the datapath controls
// an instruction needs during its execute cycle, plus the classification
// bits the sequencer uses for branching, halting and flag capture. Gating to
// the execute cycle is done by the sequencer, not here.
module instr_decoder
    import cu_pkg::*;
(
    input  logic [15:0] ir,
    output dp_ctrl_t    ctrl,
    output logic        is_branch,
    output logic        is_halt,
    output logic        sets_flags
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm;

    assign op  = ir[OP_MSB:OP_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign ra  = ir[RA_MSB:RA_LSB];
    assign rb  = ir[RB_MSB:RB_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    // Map the opcode to controls; everything defaults to an idle datapath
    always_comb begin
        ctrl       = '0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        sets_flags = 1'b0;

        if (is_alu_rr(op)) begin
            ctrl.alu_opcode = op;
            ctrl.write_addr = rd;
            ctrl.ra_addr    = ra;
            ctrl.rb_addr    = rb;
            ctrl.imm_flag   = 1'b0;
            ctrl.alu_en     = 1'b1;
            ctrl.write_en   = 1'b1;
            sets_flags      = 1'b1;
        end else begin
            case (op)
                OP_ALUI: begin
                    ctrl.alu_opcode = OP_ADD;
                    ctrl.write_addr = rd;
                    ctrl.ra_addr    = rd;
                    ctrl.imm_value  = imm;
                    ctrl.imm_flag   = 1'b1;
                    ctrl.alu_en     = 1'b1;
                    ctrl.write_en   = 1'b1;
                    sets_flags      = 1'b1;
                end
                OP_LDI: begin
                    ctrl.write_addr = rd;
                    ctrl.imm_value  = imm;
                    ctrl.alu_en     = 1'b0;
                    ctrl.write_en   = 1'b1;
                end
                OP_JMP, OP_BZ, OP_BC: begin
                    // The datapath ALU computes R[rd] + imm as the target
                    ctrl.alu_opcode = OP_ADD;
                    ctrl.ra_addr    = rd;
                    ctrl.imm_value  = imm;
                    ctrl.imm_flag   = 1'b1;
                    is_branch       = 1'b1;
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit register/ALU datapath. Fetches an
// instruction, spends one cycle in decode, drives the datapath for exactly
// one execute cycle, then advances or redirects the program counter.
module control_unit
    import cu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    control_unit_if.master    imem,
    output logic              alu_en,
    output logic [3:0]        alu_opcode,
    output logic [7:0]        imm_value,
    output logic [3:0]        write_addr,
    output logic [3:0]        ra_addr,
    output logic [3:0]        rb_addr,
    output logic              write_en,
    output logic              imm_flag,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic [7:0]        jump_target,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    cu_state_t          state;
    cu_state_t          next_state;
    logic [INSTR_W-1:0] ir;
    logic               zero_flag;
    logic               carry_flag;
    logic [3:0]         ir_op;

    dp_ctrl_t           dec_ctrl;
    logic               is_branch;
    logic               is_halt;
    logic               sets_flags;
    logic               branch_taken;

    assign ir_op = ir[OP_MSB:OP_LSB];

    instr_decoder u_decoder (
        .ir         (ir[15:0]),
        .ctrl       (dec_ctrl),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .sets_flags (sets_flags)
    );

    // State register; reset forces IDLE so imem_req drops without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE and HALT
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem.imem_valid) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                next_state = is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    next_state = ST_FETCH;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Branch condition evaluated against the flags latched by earlier ALU ops
    always_comb begin
        branch_taken = 1'b0;
        if (is_branch) begin
            case (ir_op)
                OP_JMP:  branch_taken = 1'b1;
                OP_BZ:   branch_taken = zero_flag;
                OP_BC:   branch_taken = carry_flag;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Architectural state: pc, instruction register and ALU flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            ir         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        ir <= imem.imem_data;
                    end
                end
                ST_EXECUTE: begin
                    if (sets_flags) begin
                        zero_flag  <= alu_zero;
                        carry_flag <= alu_carry;
                    end
                    if (!is_halt) begin
                        if (branch_taken) begin
                            pc <= PC_W'(jump_target);
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        pc         <= '0;
                        zero_flag  <= 1'b0;
                        carry_flag <= 1'b0;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // Datapath controls are live only in EXECUTE so no stray register writes occur
    always_comb begin
        alu_en     = 1'b0;
        alu_opcode = '0;
        imm_value  = '0;
        write_addr = '0;
        ra_addr    = '0;
        rb_addr    = '0;
        write_en   = 1'b0;
        imm_flag   = 1'b0;
        if (state == ST_EXECUTE) begin
            alu_en     = dec_ctrl.alu_en;
            alu_opcode = dec_ctrl.alu_opcode;
            imm_value  = dec_ctrl.imm_value;
            write_addr = dec_ctrl.write_addr;
            ra_addr    = dec_ctrl.ra_addr;
            rb_addr    = dec_ctrl.rb_addr;
            write_en   = dec_ctrl.write_en;
            imm_flag   = dec_ctrl.imm_flag;
        end
    end

    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign halted         = (state == ST_HALT);

endmodule
